// File: rtl/sol32lsu_if.sv
// Memory-side request/acknowledge bus of sol32lsu.
// master = load/store unit, slave = memory.
interface sol32lsu_if;
   logic        BusRequest;
   logic        BusWrite;
   logic [31:0] BusAddress;
   logic [3:0]  BusByteEnable;
   logic [31:0] BusWriteData;
   logic [31:0] BusReadData;
   logic        BusAcknowledge;
   logic        BusError;

   modport master (output BusRequest, BusWrite, BusAddress, BusByteEnable, BusWriteData,
                   input  BusReadData, BusAcknowledge, BusError);
   modport slave  (input  BusRequest, BusWrite, BusAddress, BusByteEnable, BusWriteData,
                   output BusReadData, BusAcknowledge, BusError);
endinterface

// File: rtl/sol32lsu.sv
// sol32 load/store unit: core data port to word-aligned, byte-enabled request/ack bus.
// Optional MISALIGNED_SPLIT_EN: misaligned half/word accesses split into up to two beats.
module sol32lsu #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ReadEnable,
   input  logic        WriteEnable,
   input  logic [1:0]  DataWidth,
   input  logic [31:0] MemoryAddress,
   input  logic [31:0] DataOut,
   output logic [31:0] DataIn,
   output logic        ReadComplete,
   output logic        WriteComplete,
   output logic        Fault,
   sol32lsu_if.master  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, SECOND, RESPOND} stateT;

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   stateT       state;
   logic        isWrite, isSplit;
   logic [1:0]  offsetReg, widthReg;
   logic [3:0]  enableHigh;
   logic [31:0] writeHigh, readLow;
   logic [7:0]  timer;

   logic [1:0]  offset;
   logic [7:0]  widthMask, laneEnable;
   logic [63:0] laneData;
   logic        legal, illegal;
   logic [63:0] readWindow;
   logic [31:0] readShifted, loadValue;
   logic        inBeat, goSecond, finish, finishFault;
`ifndef MISALIGNED_SPLIT_EN
   logic        aligned;
`endif

   // Lanes are computed over an 8-byte window: the upper nibble is the second beat.
   always_comb begin
      offset = MemoryAddress[1:0];
      case (DataWidth)
         2'b00:   widthMask = 8'h01;
         2'b01:   widthMask = 8'h03;
         default: widthMask = 8'h0F;
      endcase
      laneEnable = widthMask << offset;
      laneData   = (DataWidth == 2'b00) ? {8{DataOut[7:0]}}
                                        : ({32'b0, DataOut} << {offset, 3'b000});
`ifdef MISALIGNED_SPLIT_EN
      legal = DataWidth != 2'b11;
`else
      aligned = (DataWidth == 2'b00) || (DataWidth == 2'b01 && !offset[0])
             || (DataWidth == 2'b10 && offset == 2'b00);
      legal   = aligned;
`endif
      illegal = (ReadEnable && WriteEnable) || !legal;
   end

   always_comb begin
      readWindow  = isSplit ? {bus.BusReadData, readLow} : {32'b0, bus.BusReadData};
      readShifted = 32'(readWindow >> {offsetReg, 3'b000});
      case (widthReg)
         2'b00:   loadValue = {24'b0, readShifted[7:0]};
         2'b01:   loadValue = {16'b0, readShifted[15:0]};
         default: loadValue = readShifted;
      endcase
   end

   always_comb begin
      inBeat      = (state == ACCESS) || (state == SECOND);
      goSecond    = inBeat && bus.BusAcknowledge && !bus.BusError && state == ACCESS && isSplit;
      finish      = inBeat && !goSecond && (bus.BusAcknowledge || timer == TimeoutLast);
      finishFault = !bus.BusAcknowledge || bus.BusError;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state             <= IDLE;
         DataIn            <= '0;
         ReadComplete      <= 1'b0;
         WriteComplete     <= 1'b0;
         Fault             <= 1'b0;
         bus.BusRequest    <= 1'b0;
         bus.BusWrite      <= 1'b0;
         bus.BusAddress    <= '0;
         bus.BusByteEnable <= '0;
         bus.BusWriteData  <= '0;
         isWrite           <= 1'b0;
         isSplit           <= 1'b0;
         offsetReg         <= '0;
         widthReg          <= '0;
         enableHigh        <= '0;
         writeHigh         <= '0;
         readLow           <= '0;
         timer             <= '0;
      end else begin
         ReadComplete  <= 1'b0;
         WriteComplete <= 1'b0;
         Fault         <= 1'b0;
         case (state)
            IDLE: if (ReadEnable || WriteEnable) begin
               if (illegal) begin
                  state  <= RESPOND;
                  Fault  <= 1'b1;
                  DataIn <= '0;
                  if (WriteEnable && !ReadEnable) WriteComplete <= 1'b1;
                  else                            ReadComplete  <= 1'b1;
               end else begin
                  state             <= ACCESS;
                  bus.BusRequest    <= 1'b1;
                  bus.BusWrite      <= WriteEnable;
                  bus.BusAddress    <= {MemoryAddress[31:2], 2'b00};
                  bus.BusByteEnable <= laneEnable[3:0];
                  bus.BusWriteData  <= laneData[31:0];
                  enableHigh        <= laneEnable[7:4];
                  writeHigh         <= laneData[63:32];
                  isWrite           <= WriteEnable;
                  isSplit           <= |laneEnable[7:4];
                  offsetReg         <= offset;
                  widthReg          <= DataWidth;
                  timer             <= '0;
               end
            end
            ACCESS, SECOND: begin
               if (goSecond) begin
                  state             <= SECOND;
                  readLow           <= bus.BusReadData;
                  bus.BusAddress    <= bus.BusAddress + 32'd4;
                  bus.BusByteEnable <= enableHigh;
                  bus.BusWriteData  <= writeHigh;
                  timer             <= '0;
               end else if (finish) begin
                  state          <= RESPOND;
                  bus.BusRequest <= 1'b0;
                  Fault          <= finishFault;
                  if (isWrite) WriteComplete <= 1'b1;
                  else         ReadComplete  <= 1'b1;
                  if (finishFault)   DataIn <= '0;
                  else if (!isWrite) DataIn <= loadValue;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sol32lsu.sv
// Self-checking bench for sol32lsu: byte-level memory model, latency/beat model, random traffic.
module tb_sol32lsu;
   localparam int T = 4;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReadEnable, WriteEnable;
   logic [1:0]  DataWidth;
   logic [31:0] MemoryAddress, DataOut, DataIn;
   logic        ReadComplete, WriteComplete, Fault;

   sol32lsu_if bus();

   sol32lsu #(.TIMEOUT_CYCLES(T)) dut (
      .Clock(Clock), .Reset(Reset),
      .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
      .DataWidth(DataWidth), .MemoryAddress(MemoryAddress), .DataOut(DataOut),
      .DataIn(DataIn), .ReadComplete(ReadComplete), .WriteComplete(WriteComplete),
      .Fault(Fault), .bus(bus)
   );

   always #5 Clock = ~Clock;

   int nChecks = 0;
   int nErrors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Byte-addressed memories: busMem is what the bus beats did, refMem what the core asked for.
   logic [7:0] busMem[int unsigned];
   logic [7:0] refMem[int unsigned];

   function automatic logic [7:0] initByte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction
   function automatic logic [7:0] busByte(input logic [31:0] a);
      return busMem.exists(a) ? busMem[a] : initByte(a);
   endfunction
   function automatic logic [7:0] refByte(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : initByte(a);
   endfunction
   task automatic preload(input logic [31:0] wa, input logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         busMem[wa + i] = v[8*i +: 8];
         refMem[wa + i] = v[8*i +: 8];
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        wr;
   } beatT;

   beatT beatQ[$];
   int   reqCycles = 0;
   int   beatDelay[2];
   bit   beatErr[2];

   // Bus responder: acks beat n after beatDelay[n] wait cycles.
   int          waitCnt = 0;
   int          beatIdx = 0;
   beatT        rb;
   logic [31:0] rword;
   always @(negedge Clock) begin
      bus.BusAcknowledge = 1'b0;
      bus.BusError       = 1'b0;
      if (Reset !== 1'b1 || bus.BusRequest !== 1'b1) begin
         waitCnt = 0;
         beatIdx = 0;
      end else begin
         reqCycles++;
         if (beatIdx < 2 && waitCnt == beatDelay[beatIdx]) begin
            rb.addr  = bus.BusAddress;
            rb.be    = bus.BusByteEnable;
            rb.wdata = bus.BusWriteData;
            rb.wr    = bus.BusWrite;
            for (int i = 0; i < 4; i++) rword[8*i +: 8] = busByte(rb.addr + i);
            bus.BusReadData    = rword;
            bus.BusAcknowledge = 1'b1;
            bus.BusError       = beatErr[beatIdx];
            if (rb.wr && !beatErr[beatIdx])
               for (int i = 0; i < 4; i++)
                  if (rb.be[i]) busMem[rb.addr + i] = rb.wdata[8*i +: 8];
            beatQ.push_back(rb);
            beatIdx++;
            waitCnt = 0;
         end else begin
            waitCnt++;
         end
      end
   end

   // One core access, checked against the model; returns observations for literal checks.
   task automatic doTxn(input bit rd, input bit wr, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input int d0, input int d1, input bit e0,
                        input bit e1, output logic [31:0] gotData, output logic gotFault,
                        output int gotCyc, output int q0);
      int size, nBeats, t, acked, written, reqExp, reqStart, j;
      int dl[2];
      bit el[2];
      bit ill, fault, rc, wc;
      logic [31:0] base, expData, b;
      logic [3:0] be;
      beatT bt;

      size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
`ifdef MISALIGNED_SPLIT_EN
      ill = (rd && wr) || w == 2'd3;
`else
      ill = (rd && wr) || w == 2'd3 || (a % size) != 0;
`endif
      nBeats = ill ? 0 : ((int'(a[1:0]) + size > 4) ? 2 : 1);
      base   = {a[31:2], 2'b00};
      dl[0] = d0; dl[1] = d1; el[0] = e0; el[1] = e1;
      t = 0; acked = 0; written = 0; reqExp = 0; fault = ill;
      for (int k = 0; k < nBeats; k++) begin
         if (dl[k] >= T) begin t += T; reqExp += T; fault = 1; break; end
         t += dl[k] + 1; reqExp += dl[k] + 1; acked++;
         if (el[k]) begin fault = 1; break; end
         written++;
      end
      expData = '0;
      if (!fault && rd)
         for (int i = 0; i < size; i++) expData[8*i +: 8] = refByte(a + i);

      beatDelay[0] = d0; beatDelay[1] = d1; beatErr[0] = e0; beatErr[1] = e1;
      q0 = beatQ.size();
      reqStart = reqCycles;
      ReadEnable = rd; WriteEnable = wr; DataWidth = w; MemoryAddress = a; DataOut = d;
      gotCyc = -1; rc = 0; wc = 0; gotFault = 0; gotData = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge Clock);
         if (ReadComplete || WriteComplete) begin
            gotCyc = c; rc = ReadComplete; wc = WriteComplete;
            gotFault = Fault; gotData = DataIn;
            break;
         end
      end
      @(posedge Clock);
      #1;
      ReadEnable = 0; WriteEnable = 0;
      @(negedge Clock);
      check("complete pulse width", 32'({ReadComplete, WriteComplete}), 32'd0);
      check("completion cycle", gotCyc, t + 1);
      if (rd && wr) check("single complete", 32'(rc ^ wc), 32'd1);
      else          check("complete kind", 32'({rc, wc}), 32'({rd, wr}));
      check("fault", 32'(gotFault), 32'(fault));
      if (fault || !wr) check("load data", gotData, expData);
      check("request cycles", reqCycles - reqStart, reqExp);
      check("beats acked", beatQ.size() - q0, acked);
      for (int k = 0; k < acked && q0 + k < beatQ.size(); k++) begin
         bt = beatQ[q0 + k];
         be = '0;
         for (int i = 0; i < size; i++) begin
            b = a + i;
            if (int'(b >> 2) - int'(a >> 2) == k) be[b[1:0]] = 1'b1;
         end
         check("beat address", bt.addr, base + 32'(4 * k));
         check("beat enables", 32'(bt.be), 32'(be));
         check("beat direction", 32'(bt.wr), 32'(wr));
      end
      if (wr && !ill)
         for (int i = 0; i < size; i++) begin
            b = a + i;
            j = int'(b >> 2) - int'(a >> 2);
            if (j < written) refMem[b] = d[8*i +: 8];
         end
      @(posedge Clock);
      #1;
   endtask

   function automatic int pickDelay();
      int r;
      r = $urandom_range(0, 15);
      if (r < 10) return $urandom_range(0, 1);
      if (r < 14) return $urandom_range(2, T - 1);
      return $urandom_range(T, T + 1);
   endfunction

   logic [31:0] gd;
   logic        gf;
   int          gc, q0, mm;
   bit          rdR, wrR;
   logic [1:0]  wR;

   initial begin
      Reset = 1'b0;
      ReadEnable = 0; WriteEnable = 0; DataWidth = 0; MemoryAddress = 0; DataOut = 0;
      beatDelay[0] = 0; beatDelay[1] = 0; beatErr[0] = 0; beatErr[1] = 0;
      repeat (3) @(posedge Clock);
      #1;
      check("reset BusRequest", 32'(bus.BusRequest), 32'd0);
      check("reset completes", 32'({ReadComplete, WriteComplete, Fault}), 32'd0);
      check("reset DataIn", DataIn, 32'd0);
      check("reset BusByteEnable", 32'(bus.BusByteEnable), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      #1;

      preload(32'h1000, 32'hDEADBEEF);
      doTxn(1, 0, 2'd2, 32'h1000, 0, 0, 0, 0, 0, gd, gf, gc, q0);
      check("word load data", gd, 32'hDEADBEEF);
      check("word load cycle", gc, 2);
      check("word load enables", 32'(beatQ[q0].be), 32'hF);

      doTxn(0, 1, 2'd0, 32'h1003, 32'h000000A5, 1, 0, 0, 0, gd, gf, gc, q0);
      check("byte store address", beatQ[q0].addr, 32'h1000);
      check("byte store enables", 32'(beatQ[q0].be), 32'h8);
      check("byte store data", beatQ[q0].wdata, 32'hA5A5A5A5);
      check("byte store memory", 32'(busByte(32'h1003)), 32'hA5);

      preload(32'h2000, 32'h12345678);
      doTxn(1, 0, 2'd1, 32'h2002, 0, 0, 0, 0, 0, gd, gf, gc, q0);
      check("half load data", gd, 32'h00001234);
      check("half load enables", 32'(beatQ[q0].be), 32'hC);

      preload(32'h3000, 32'h44332211);
      preload(32'h3004, 32'h88776655);
      doTxn(1, 0, 2'd2, 32'h3001, 0, 0, 0, 0, 0, gd, gf, gc, q0);
`ifdef MISALIGNED_SPLIT_EN
      check("split load data", gd, 32'h55443322);
      check("split load cycle", gc, 3);
      check("split beat0 enables", 32'(beatQ[q0].be), 32'hE);
      check("split beat1 address", beatQ[q0 + 1].addr, 32'h3004);
      check("split beat1 enables", 32'(beatQ[q0 + 1].be), 32'h1);
`else
      check("misaligned fault", 32'(gf), 32'd1);
      check("misaligned cycle", gc, 1);
      check("misaligned no beat", beatQ.size() - q0, 0);
`endif

      doTxn(1, 0, 2'd2, 32'h1000, 0, 255, 0, 0, 0, gd, gf, gc, q0);
      check("timeout fault", 32'(gf), 32'd1);
      check("timeout cycle", gc, T + 1);
      doTxn(1, 0, 2'd2, 32'h1000, 0, 1, 0, 1, 0, gd, gf, gc, q0);
      check("bus error fault", 32'(gf), 32'd1);
      doTxn(1, 1, 2'd2, 32'h1000, 0, 0, 0, 0, 0, gd, gf, gc, q0);
      check("both enables fault", 32'(gf), 32'd1);
      doTxn(1, 0, 2'd3, 32'h1000, 0, 0, 0, 0, 0, gd, gf, gc, q0);
      check("reserved width fault", 32'(gf), 32'd1);
      doTxn(1, 0, 2'd2, 32'h1000, 0, T - 1, 0, 0, 0, gd, gf, gc, q0);
      check("last-cycle ack ok", 32'(gf), 32'd0);

      // Reset while a beat is outstanding.
      beatDelay[0] = 255;
      ReadEnable = 1; WriteEnable = 0; DataWidth = 2'd2; MemoryAddress = 32'h1000;
      @(negedge Clock);
      @(negedge Clock);
      check("request before reset", 32'(bus.BusRequest), 32'd1);
      #2 Reset = 1'b0;
      #1;
      check("request cleared by reset", 32'(bus.BusRequest), 32'd0);
      check("DataIn cleared by reset", DataIn, 32'd0);
      check("completes cleared by reset", 32'({ReadComplete, WriteComplete, Fault}), 32'd0);
      ReadEnable = 0;
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      doTxn(1, 0, 2'd1, 32'h2002, 0, 0, 0, 0, 0, gd, gf, gc, q0);
      check("load after reset", gd, 32'h00001234);

      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 19) == 0) begin rdR = 1; wrR = 1; end
         else begin rdR = 1'($urandom_range(0, 1)); wrR = !rdR; end
         wR = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         doTxn(rdR, wrR, wR, 32'h100 + 32'($urandom_range(0, 31)), $urandom,
               pickDelay(), pickDelay(), $urandom_range(0, 11) == 0,
               $urandom_range(0, 11) == 0, gd, gf, gc, q0);
      end

      mm = 0;
      foreach (busMem[k]) if (busMem[k] !== refByte(k)) mm++;
      foreach (refMem[k]) if (refMem[k] !== busByte(k)) mm++;
      check("memory image", mm, 0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", nErrors);
      $fatal(1);
   end
endmodule
